fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: reads a burst of words from a FIFO and streams them to a
// ready/valid consumer.
// FIFO read data arrives the cycle after the pop. That word is presented
// downstream directly when the 2-entry output buffer is empty. Otherwise it
// is queued behind the buffered words. This keeps first-word latency at two
// cycles and sustains one word per cycle under a constant i_ready.
module fifo_rd_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_burst_len,
    input  logic             i_abort,
    input  logic             i_fifo_empty,
    input  logic [WIDTH-1:0] i_fifo_rd_data,
    output logic             o_fifo_rd_en,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] req_cnt;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic             vld_p1;      // a popped word is on i_fifo_rd_data this cycle
    logic             done_q;
    logic [WIDTH-1:0] buf_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;
    logic [1:0]       pend;
    logic             run;
    logic             xfer;
    logic             push;
    logic             pop;
    logic             last;

    // Request gating, output selection and buffer push/pop decisions
    always_comb begin
        run          = (state == S_RUN);
        pend         = occ + {1'b0, vld_p1};
        o_fifo_rd_en = run & ~i_fifo_empty & (req_cnt < len_q) &
                       (pend < 2'd2) & ~i_abort;
        o_valid      = run & ((occ != 2'd0) | vld_p1);
        if (!run)
            o_data = '0;
        else if (occ != 2'd0)
            o_data = buf_mem[rd_ptr];
        else if (vld_p1)
            o_data = i_fifo_rd_data;
        else
            o_data = '0;
        xfer    = o_valid & i_ready;
        // The arriving word is stored unless it bypasses straight out.
        push    = run & ~i_abort & vld_p1 & ~((occ == 2'd0) & xfer);
        pop     = xfer & (occ != 2'd0);
        cnt_inc = cnt_q + 1'b1;
        last    = xfer & (cnt_inc == len_q);
        o_busy  = (state == S_RUN) | (state == S_FLUSH);
        o_done  = done_q;
        o_count = cnt_q;
    end

    // Control state: FSM, counters, in-flight flag and buffer pointers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            len_q   <= '0;
            req_cnt <= '0;
            cnt_q   <= '0;
            vld_p1  <= 1'b0;
            done_q  <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            occ     <= 2'd0;
        end else begin
            done_q <= 1'b0;
            vld_p1 <= o_fifo_rd_en;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        cnt_q <= '0;
                        if (i_burst_len != '0) begin
                            len_q   <= i_burst_len;
                            req_cnt <= '0;
                            state   <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (o_fifo_rd_en)
                        req_cnt <= req_cnt + 1'b1;
                    if (xfer)
                        cnt_q <= cnt_inc;
                    if (i_abort) begin
                        occ    <= 2'd0;
                        rd_ptr <= 1'b0;
                        wr_ptr <= 1'b0;
                        state  <= S_FLUSH;
                    end else begin
                        occ <= occ + {1'b0, push} - {1'b0, pop};
                        if (push)
                            wr_ptr <= ~wr_ptr;
                        if (pop)
                            rd_ptr <= ~rd_ptr;
                        if (last) begin
                            state  <= S_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Any word still arriving is simply not captured.
                    occ    <= 2'd0;
                    rd_ptr <= 1'b0;
                    wr_ptr <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output buffer storage; contents are qualified by occ, so no reset
    always_ff @(posedge i_clk) begin
        if (push)
            buf_mem[wr_ptr] <= i_fifo_rd_data;
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Testbench for fifo_rd_ctrl: directed bursts against a simple FIFO model.
module tb_fifo_rd_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_burst_len;
    logic       i_abort;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_rd_data;
    logic       o_fifo_rd_en;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_count;

    int n_chk  = 0;
    int n_pass = 0;

    // FIFO model: synchronous read, data valid the cycle after the pop
    logic [7:0] mem [128];
    int         wr_i = 0;
    int         rd_i = 0;
    logic       fifo_clr;

    // Transfer/pop monitor
    logic       mon_clr;
    logic [7:0] got [16];
    int         got_n = 0;
    int         pop_n = 0;
    int         outst = 0;
    int         max_out = 0;
    int         out_tmp;

    fifo_rd_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_burst_len    (i_burst_len),
        .i_abort        (i_abort),
        .i_fifo_empty   (i_fifo_empty),
        .i_fifo_rd_data (i_fifo_rd_data),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_count        (o_count)
    );

    always #5 i_clk = ~i_clk;

    assign i_fifo_empty = (wr_i == rd_i);

    // FIFO pop side
    always @(posedge i_clk) begin
        if (fifo_clr)
            rd_i <= wr_i;
        else if (o_fifo_rd_en && (wr_i != rd_i)) begin
            i_fifo_rd_data <= mem[rd_i];
            rd_i           <= rd_i + 1;
        end
    end

    // Record delivered words, pops and the pop-minus-transfer depth
    always @(posedge i_clk) begin
        if (mon_clr) begin
            got_n   <= 0;
            pop_n   <= 0;
            outst   <= 0;
            max_out <= 0;
        end else begin
            out_tmp = outst;
            if (o_fifo_rd_en && !i_fifo_empty) begin
                pop_n   <= pop_n + 1;
                out_tmp = out_tmp + 1;
            end
            if (o_valid && i_ready) begin
                got[got_n[3:0]] <= o_data;
                got_n           <= got_n + 1;
                out_tmp = out_tmp - 1;
            end
            outst <= out_tmp;
            if (out_tmp > max_out)
                max_out <= out_tmp;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_i] = base + i[7:0];
            wr_i      = wr_i + 1;
        end
    endtask

    task automatic clr_mon();
        nxt(); mon_clr = 1'b1;
        nxt(); mon_clr = 1'b0;
    endtask

    task automatic clr_fifo();
        nxt(); fifo_clr = 1'b1;
        nxt(); fifo_clr = 1'b0;
    endtask

    task automatic check_seq(input string tag, input logic [7:0] base, input int n);
        check({tag, "_n"}, got_n, n);
        for (int i = 0; i < n; i++)
            check({tag, "_word"}, got[i], base + i[7:0]);
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_burst_len = '0; i_abort = 1'b0;
        i_ready = 1'b0; fifo_clr = 1'b1; mon_clr = 1'b1;

        // Reset state
        nxt(); nxt(); #1;
        check("rst_rd_en", o_fifo_rd_en, 0);
        check("rst_valid", o_valid, 0);
        check("rst_data",  o_data, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_done",  o_done, 0);
        check("rst_count", o_count, 0);
        nxt(); i_rst_n = 1'b1; fifo_clr = 1'b0; mon_clr = 1'b0;

        // Streaming burst of 5
        load(8'h10, 5); i_ready = 1'b1;
        nxt(); i_start = 1'b1; i_burst_len = 8'd5;
        nxt(); i_start = 1'b0; #1;
        check("st_rd_en1", o_fifo_rd_en, 1);
        check("st_valid0", o_valid, 0);
        check("st_busy",   o_busy, 1);
        for (int k = 0; k < 5; k++) begin
            nxt(); #1;
            check("st_valid", o_valid, 1);
            check("st_data",  o_data, 8'h10 + k);
        end
        nxt(); #1;
        check("st_done",  o_done, 1);
        check("st_count", o_count, 5);
        check("st_idle",  o_busy, 0);
        nxt(); #1;
        check("st_done_pulse", o_done, 0);

        // Backpressure: ready low for 3 cycles from first o_valid
        clr_mon(); load(8'h20, 4); i_ready = 1'b0;
        nxt(); i_start = 1'b1; i_burst_len = 8'd4;
        nxt(); i_start = 1'b0; #1;
        check("bp_rd_en1", o_fifo_rd_en, 1);
        nxt(); #1;
        check("bp_valid", o_valid, 1);
        check("bp_data0", o_data, 8'h20);
        check("bp_rd_en2", o_fifo_rd_en, 1);
        nxt(); #1;
        check("bp_hold1", o_data, 8'h20);
        check("bp_stall1", o_fifo_rd_en, 0);
        nxt(); #1;
        check("bp_hold2", o_data, 8'h20);
        check("bp_stall2", o_fifo_rd_en, 0);
        nxt(); i_ready = 1'b1; #1;
        check("bp_hold3", o_data, 8'h20);
        check("bp_full", o_fifo_rd_en, 0);
        nxt(); nxt(); nxt(); nxt(); #1;
        check("bp_done",  o_done, 1);
        check("bp_count", o_count, 4);
        check("bp_max_out", max_out, 2);
        check_seq("bp_seq", 8'h20, 4);

        // Empty stall: 2 words, refill later; a start mid-burst is ignored
        clr_mon(); load(8'h30, 2);
        nxt(); i_start = 1'b1; i_burst_len = 8'd4;
        nxt(); i_start = 1'b0; #1;
        check("es_rd_en1", o_fifo_rd_en, 1);
        nxt(); #1;
        check("es_data0", o_data, 8'h30);
        nxt(); #1;
        check("es_data1", o_data, 8'h31);
        check("es_empty_rd_en", o_fifo_rd_en, 0);
        for (int k = 0; k < 4; k++) begin
            nxt(); i_start = (k == 1); i_burst_len = 8'd1; #1;
            check("es_stall_rd_en", o_fifo_rd_en, 0);
            check("es_stall_busy", o_busy, 1);
        end
        nxt(); i_start = 1'b0; load(8'h32, 2); #1;
        check("es_resume", o_fifo_rd_en, 1);
        nxt(); #1;
        check("es_data2", o_data, 8'h32);
        nxt(); #1;
        check("es_data3", o_data, 8'h33);
        nxt(); #1;
        check("es_done",  o_done, 1);
        check("es_count", o_count, 4);
        check_seq("es_seq", 8'h30, 4);

        // Abort with one word buffered and one in flight after 2 delivered
        clr_mon(); load(8'h40, 8);
        nxt(); i_start = 1'b1; i_burst_len = 8'd6;
        nxt(); i_start = 1'b0;
        nxt(); nxt();
        nxt(); i_ready = 1'b0; #1;
        check("ab_bypass", o_data, 8'h42);
        nxt(); i_abort = 1'b1; #1;
        check("ab_no_pop", o_fifo_rd_en, 0);
        check("ab_valid_now", o_valid, 1);
        nxt(); i_abort = 1'b0; #1;
        check("ab_valid_low", o_valid, 0);
        check("ab_flush_busy", o_busy, 1);
        check("ab_flush_rd_en", o_fifo_rd_en, 0);
        check("ab_flush_done", o_done, 0);
        nxt(); #1;
        check("ab_idle", o_busy, 0);
        check("ab_no_done", o_done, 0);
        check("ab_count", o_count, 2);
        check("ab_pops", pop_n, 4);
        clr_fifo();

        // Zero-length start
        clr_mon(); load(8'h70, 1);
        nxt(); i_start = 1'b1; i_burst_len = 8'd0;
        nxt(); i_start = 1'b0; #1;
        check("zl_done", o_done, 1);
        check("zl_count", o_count, 0);
        check("zl_busy", o_busy, 0);
        check("zl_rd_en", o_fifo_rd_en, 0);
        nxt(); #1;
        check("zl_done_pulse", o_done, 0);
        check("zl_pops", pop_n, 0);
        clr_fifo();

        // Reset mid-burst, then a fresh burst of 3
        clr_mon(); load(8'h50, 4); i_ready = 1'b0;
        nxt(); i_start = 1'b1; i_burst_len = 8'd4;
        nxt(); i_start = 1'b0;
        nxt(); nxt(); nxt();
        i_rst_n = 1'b0; fifo_clr = 1'b1; mon_clr = 1'b1; #1;
        check("mr_rd_en", o_fifo_rd_en, 0);
        check("mr_valid", o_valid, 0);
        check("mr_data",  o_data, 0);
        check("mr_busy",  o_busy, 0);
        check("mr_done",  o_done, 0);
        check("mr_count", o_count, 0);
        nxt(); fifo_clr = 1'b0; mon_clr = 1'b0; load(8'h60, 3); #1;
        check("mr_hold_valid", o_valid, 0);
        nxt(); i_rst_n = 1'b1; i_start = 1'b1; i_burst_len = 8'd3; i_ready = 1'b1;
        nxt(); i_start = 1'b0; #1;
        check("mr_first_start", o_fifo_rd_en, 1);
        for (int k = 0; k < 3; k++) begin
            nxt(); #1;
            check("mr_data_new", o_data, 8'h60 + k);
        end
        nxt(); #1;
        check("mr_done_new", o_done, 1);
        check("mr_count_new", o_count, 3);
        nxt(); #1;
        check_seq("mr_seq", 8'h60, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
